// File: rtl/gcd_job_scheduler.sv
// Purpose : shares one GCD core between N_REQ requesters; round-robin arbitration, tagged responses.
// Latency : zero-operand bypass responds 1 cycle after accept; core jobs respond 1 cycle after core_done_i,
//           or 3+TO_CYCLES cycles after accept when the core times out and is aborted.
// Backpressure: one job in flight; req_ready_o stays 0 until the pending response is taken (rsp_ready_i).
//
// Ports:
//   clk, rst                    clock (rising edge), asynchronous active-low reset
//   req_valid_i/req_a_i/req_b_i per-requester operand pairs, requester k at [k*WIDTH +: WIDTH]
//   req_ready_o                 one-hot accept, only while idle
//   rsp_valid_o/rsp_id_o/rsp_result_o/rsp_err_o, rsp_ready_i   tagged response channel
//   core_start_o/core_abort_o/core_a_o/core_b_o/core_done_i/core_result_i   GCD core handshake
//   busy_o                      a job is in progress (state != IDLE)
module gcd_job_scheduler #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 16,
    parameter int TO_CYCLES = 1024,
    localparam int ID_W     = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid_i,
    input  logic [N_REQ*WIDTH-1:0] req_a_i,
    input  logic [N_REQ*WIDTH-1:0] req_b_i,
    output logic [N_REQ-1:0]       req_ready_o,
    output logic                   rsp_valid_o,
    output logic [ID_W-1:0]        rsp_id_o,
    output logic [WIDTH-1:0]       rsp_result_o,
    output logic                   rsp_err_o,
    input  logic                   rsp_ready_i,
    output logic                   core_start_o,
    output logic                   core_abort_o,
    output logic [WIDTH-1:0]       core_a_o,
    output logic [WIDTH-1:0]       core_b_o,
    input  logic                   core_done_i,
    input  logic [WIDTH-1:0]       core_result_i,
    output logic                   busy_o
);

    localparam int CNT_W = $clog2(TO_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ABORT,
        S_RESP
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   last_grant;
    logic [CNT_W-1:0]  cnt;

    logic              win_found;
    logic [ID_W-1:0]   win_id;
    logic [WIDTH-1:0]  win_a;
    logic [WIDTH-1:0]  win_b;

    // Round-robin pick: scan from last_grant+1 upward with wrap; the previous
    // winner is checked last so a continuously valid requester waits at most
    // N_REQ-1 other jobs.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!win_found && req_valid_i[(int'(last_grant) + i) % N_REQ]) begin
                win_found = 1'b1;
                win_id    = ID_W'((int'(last_grant) + i) % N_REQ);
            end
        end
    end

    assign win_a = req_a_i[int'(win_id)*WIDTH +: WIDTH];
    assign win_b = req_b_i[int'(win_id)*WIDTH +: WIDTH];

    // Accept is combinational in IDLE; gated by rst so every output reads 0
    // while reset is held even if requesters keep their valids up.
    always_comb begin
        req_ready_o = '0;
        if (rst && state == S_IDLE && win_found) begin
            req_ready_o[win_id] = 1'b1;
        end
    end

    assign busy_o = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            last_grant   <= ID_W'(N_REQ - 1);
            cnt          <= '0;
            core_start_o <= 1'b0;
            core_abort_o <= 1'b0;
            core_a_o     <= '0;
            core_b_o     <= '0;
            rsp_valid_o  <= 1'b0;
            rsp_id_o     <= '0;
            rsp_result_o <= '0;
            rsp_err_o    <= 1'b0;
        end else begin
            // start/abort are single-cycle pulses
            core_start_o <= 1'b0;
            core_abort_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        last_grant <= win_id;
                        rsp_id_o   <= win_id;
                        core_a_o   <= win_a;
                        core_b_o   <= win_b;
                        // gcd(x,0) = x; the core cannot take a zero operand
                        // (its modulo step would divide by zero).
                        if (win_a == '0 || win_b == '0) begin
                            rsp_result_o <= win_a | win_b;
                            rsp_err_o    <= 1'b0;
                            rsp_valid_o  <= 1'b1;
                            state        <= S_RESP;
                        end else begin
                            core_start_o <= 1'b1;
                            state        <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    // done is checked first so it wins over a same-cycle timeout
                    if (core_done_i) begin
                        rsp_result_o <= core_result_i;
                        rsp_err_o    <= 1'b0;
                        rsp_valid_o  <= 1'b1;
                        state        <= S_RESP;
                    end else if (cnt == CNT_W'(TO_CYCLES - 1)) begin
                        core_abort_o <= 1'b1;
                        state        <= S_ABORT;
                    end
                end
                S_ABORT: begin
                    rsp_result_o <= '0;
                    rsp_err_o    <= 1'b1;
                    rsp_valid_o  <= 1'b1;
                    state        <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_job_scheduler.sv
// Directed bench for gcd_job_scheduler with a small behavioural GCD core model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_gcd_job_scheduler;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int TO  = 16;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N*W-1:0]   req_a = '0;
    logic [N*W-1:0]   req_b = '0;
    logic [N-1:0]     req_ready;
    logic             rsp_valid;
    logic [IDW-1:0]   rsp_id;
    logic [W-1:0]     rsp_result;
    logic             rsp_err;
    logic             rsp_ready = 1'b0;
    logic             core_start;
    logic             core_abort;
    logic [W-1:0]     core_a;
    logic [W-1:0]     core_b;
    logic             core_done;
    logic [W-1:0]     core_result;
    logic             busy;

    logic             force_done = 1'b0;
    logic             cm_done;
    logic [W-1:0]     cm_res, cm_a, cm_b;
    int               cm_cnt;
    int               cm_lat = 7;

    int n_checks = 0;
    int n_err    = 0;
    int start_cnt = 0;
    int abort_cnt = 0;
    int done_k;

    always #5 clk = ~clk;

    gcd_job_scheduler #(.N_REQ(N), .WIDTH(W), .TO_CYCLES(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid),
        .req_a_i       (req_a),
        .req_b_i       (req_b),
        .req_ready_o   (req_ready),
        .rsp_valid_o   (rsp_valid),
        .rsp_id_o      (rsp_id),
        .rsp_result_o  (rsp_result),
        .rsp_err_o     (rsp_err),
        .rsp_ready_i   (rsp_ready),
        .core_start_o  (core_start),
        .core_abort_o  (core_abort),
        .core_a_o      (core_a),
        .core_b_o      (core_b),
        .core_done_i   (core_done),
        .core_result_i (core_result),
        .busy_o        (busy)
    );

    function automatic logic [W-1:0] gcd16(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x = a;
        logic [W-1:0] y = b;
        logic [W-1:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Core model: done pulses cm_lat posedges after start is seen (0 = never).
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cm_cnt  <= 0;
            cm_done <= 1'b0;
            cm_res  <= '0;
        end else begin
            cm_done <= 1'b0;
            if (core_start) begin
                cm_a   <= core_a;
                cm_b   <= core_b;
                cm_cnt <= cm_lat;
            end else if (core_abort) begin
                cm_cnt <= 0;
            end else if (cm_cnt != 0) begin
                cm_cnt <= cm_cnt - 1;
                if (cm_cnt == 1) begin
                    cm_done <= 1'b1;
                    cm_res  <= gcd16(cm_a, cm_b);
                end
            end
        end
    end

    assign core_done   = cm_done | force_done;
    assign core_result = force_done ? 16'hBEEF : cm_res;

    always @(posedge clk) begin
        if (core_start) start_cnt++;
        if (core_abort) abort_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[k*W +: W] = a;
        req_b[k*W +: W] = b;
    endtask

    // Present a single request on a falling edge and check it is the one accepted.
    task automatic req_one(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        set_op(id, a, b);
        req_valid = '0;
        req_valid[id] = 1'b1;
        #1;
        check("accept", req_ready, 32'(1) << id);
    endtask

    // Advance until rsp_valid is seen; k counts sample points from k0.
    task automatic wait_rsp(input bit drop, input int k0, output int k);
        bit got = 1'b0;
        k = k0;
        done_k = -1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (drop) req_valid = '0;
            #1;
            k++;
            if (core_done && done_k < 0) done_k = k;
            if (rsp_valid) got = 1'b1;
        end
        if (!got) check("rsp_timeout", rsp_valid, 1);
    endtask

    task automatic wait_grant();
        for (int i = 0; i < 60 && req_ready == '0; i++) begin
            @(negedge clk);
            #1;
        end
        if (req_ready == '0) check("grant_timeout", req_ready != '0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        int s0;
        int a0;
        int abort_k;
        int abort_hi;
        int rsp_k;
        logic [W-1:0] t2_a [4];
        logic [W-1:0] t2_b [4];
        logic [W-1:0] t2_r [4];
        int           order [5];

        t2_a  = '{16'd12, 16'd18, 16'd100, 16'd81};
        t2_b  = '{16'd8,  16'd24, 16'd75,  16'd27};
        t2_r  = '{16'd4,  16'd6,  16'd25,  16'd27};
        order = '{0, 1, 2, 3, 0};

        // ---- reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_start", core_start, 0);
        check("rst_abort", core_abort, 0);
        check("rst_busy", busy, 0);
        check("rst_result", rsp_result, 0);
        check("rst_core_a", core_a, 0);

        // ---- all four held valid: grants 0,1,2,3,0
        rsp_ready = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < N; i++) set_op(i, t2_a[i], t2_b[i]);
        req_valid = 4'hF;
        #1;
        for (int g = 0; g < 5; g++) begin
            wait_grant();
            check("rr_grant", req_ready, 32'(1) << order[g]);
            wait_rsp(1'b0, 0, k);
            check("rr_id", rsp_id, order[g]);
            check("rr_result", rsp_result, t2_r[order[g]]);
        end

        // ---- requester 2 only, 48/18, core done after 7 cycles of WAIT
        s0 = start_cnt;
        req_one(2, 16'd48, 16'd18);
        @(negedge clk);
        req_valid = '0;
        #1;
        check("t1_start", core_start, 1);
        check("t1_core_a", core_a, 48);
        check("t1_core_b", core_b, 18);
        check("t1_busy", busy, 1);
        wait_rsp(1'b1, 1, k);
        check("t1_done_cycle", done_k, 9);
        check("t1_rsp_cycle", k, 10);
        check("t1_id", rsp_id, 2);
        check("t1_result", rsp_result, 6);
        check("t1_err", rsp_err, 0);
        check("t1_start_count", start_cnt - s0, 1);

        // ---- zero-operand bypass
        s0 = start_cnt;
        req_one(1, 16'd0, 16'd35);
        wait_rsp(1'b1, 0, k);
        check("t3_latency", k, 1);
        check("t3_id", rsp_id, 1);
        check("t3_result", rsp_result, 35);
        check("t3_err", rsp_err, 0);
        req_one(3, 16'd0, 16'd0);
        wait_rsp(1'b1, 0, k);
        check("t3z_latency", k, 1);
        check("t3z_id", rsp_id, 3);
        check("t3z_result", rsp_result, 0);
        check("t3z_err", rsp_err, 0);
        check("t3_no_start", start_cnt - s0, 0);

        // ---- timeout: core never answers
        cm_lat = 0;
        a0 = abort_cnt;
        req_one(0, 16'd9, 16'd6);
        rsp_ready = 1'b0;
        abort_k = -1;
        abort_hi = 0;
        rsp_k = -1;
        for (int i = 1; i <= 40 && rsp_k < 0; i++) begin
            @(negedge clk);
            req_valid = '0;
            #1;
            if (core_abort) begin
                if (abort_k < 0) abort_k = i;
                abort_hi++;
            end
            if (rsp_valid) rsp_k = i;
        end
        check("t4_abort_cycle", abort_k, 18);
        check("t4_abort_width", abort_hi, 1);
        check("t4_abort_count", abort_cnt - a0, 1);
        check("t4_rsp_cycle", rsp_k, 19);
        check("t4_err", rsp_err, 1);
        check("t4_result", rsp_result, 0);
        check("t4_id", rsp_id, 0);
        // late done while the error response is pending
        @(negedge clk);
        force_done = 1'b1;
        #1;
        @(negedge clk);
        force_done = 1'b0;
        #1;
        check("t4_late_valid", rsp_valid, 1);
        check("t4_late_result", rsp_result, 0);
        check("t4_late_err", rsp_err, 1);
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        @(negedge clk);
        #1;
        check("t4_drained", rsp_valid, 0);
        // late done while idle
        @(negedge clk);
        force_done = 1'b1;
        #1;
        @(negedge clk);
        force_done = 1'b0;
        #1;
        check("t4_idle_busy", busy, 0);
        check("t4_idle_valid", rsp_valid, 0);
        cm_lat = 7;

        // ---- response backpressure for 5 cycles
        rsp_ready = 1'b0;
        @(negedge clk);
        set_op(2, 16'd21, 16'd0);
        set_op(0, 16'd0, 16'd14);
        req_valid = 4'b0101;
        #1;
        check("t5_accept", req_ready, 4'b0100);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            #1;
            check("t5_hold_valid", rsp_valid, 1);
            check("t5_hold_id", rsp_id, 2);
            check("t5_hold_result", rsp_result, 21);
            check("t5_no_ready", req_ready, 0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        check("t5_sixth_valid", rsp_valid, 1);
        @(negedge clk);
        #1;
        check("t5_next_grant", req_ready, 4'b0001);
        wait_rsp(1'b1, 0, k);
        check("t5_next_latency", k, 1);
        check("t5_next_id", rsp_id, 0);
        check("t5_next_result", rsp_result, 14);

        // ---- reset during WAIT
        req_one(3, 16'd30, 16'd12);
        repeat (3) begin
            @(negedge clk);
            req_valid = '0;
        end
        @(negedge clk);
        rst = 1'b0;
        set_op(1, 16'd10, 16'd4);
        set_op(3, 16'd9, 16'd3);
        req_valid = 4'b1010;
        #1;
        check("t6_rst_valid", rsp_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_ready", req_ready, 0);
        check("t6_rst_start", core_start, 0);
        check("t6_rst_id", rsp_id, 0);
        check("t6_rst_core_a", core_a, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_first_grant", req_ready, 4'b0010);
        @(negedge clk);
        req_valid = 4'b1000;
        #1;
        check("t6_start", core_start, 1);
        check("t6_core_a", core_a, 10);
        wait_rsp(1'b0, 1, k);
        check("t6_rsp_cycle", k, 10);
        check("t6_id", rsp_id, 1);
        check("t6_result", rsp_result, 2);
        wait_grant();
        check("t6_second_grant", req_ready, 4'b1000);
        wait_rsp(1'b1, 0, k);
        check("t6_id2", rsp_id, 3);
        check("t6_result2", rsp_result, 3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/gcd_job_scheduler.md
Name: gcd_job_scheduler

Overview:
- Shares one GCD core (controller plus ALU) between N_REQ requesters.
- Arbitrates incoming operand pairs round-robin and latches the winning operands.
- Sequences the core through a start/done handshake, guarded by a timeout with abort.
- Returns each result on a single tagged response channel. Zero operands bypass the core, because modulo by zero is illegal in the ALU.

Parameters:
N_REQ, 4, number of requesters (>=2)
WIDTH, 16, operand/result width
TO_CYCLES, 1024, max cycles spent in WAIT before abort (>=2)
ID_W (local), clog2(N_REQ), requester id width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-low
req_valid_i  in  N_REQ  per-requester request valid
req_a_i  in  N_REQ*WIDTH  operand a; requester k at [k*WIDTH +: WIDTH]
req_b_i  in  N_REQ*WIDTH  operand b; same packing
req_ready_o  out  N_REQ  one-hot accept; transfer on valid&ready
rsp_valid_o  out  1  response valid
rsp_id_o  out  ID_W  requester index of response
rsp_result_o  out  WIDTH  gcd(a,b)
rsp_err_o  out  1  1 = core timed out; result forced to 0
rsp_ready_i  in  1  response consumer ready
core_start_o  out  1  one-cycle start pulse to core
core_abort_o  out  1  one-cycle abort pulse; core returns to IDLE
core_a_o  out  WIDTH  operand a to core; stable from ISSUE through WAIT
core_b_o  out  WIDTH  operand b to core
core_done_i  in  1  core result valid (one-cycle pulse)
core_result_i  in  WIDTH  core result
busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE, last_grant=N_REQ-1, timeout counter=0; all outputs 0.
- States: IDLE, ISSUE, WAIT, ABORT, RESP.
- IDLE:
  - If any req_valid_i is set, pick the first valid requester scanning from last_grant+1 mod N_REQ upward with wrap.
  - req_ready_o[winner]=1 combinationally in this cycle only; all other bits 0.
  - Latch the winner's id, a and b; set last_grant=winner.
  - If a==0 or b==0: rsp_result=a|b, err=0, go to RESP. Otherwise go to ISSUE.
- ISSUE: core_start_o=1 for one cycle; core_a_o/core_b_o = latched operands; counter=0; go to WAIT.
- WAIT: counter increments each cycle.
  - core_done_i=1: latch core_result_i, err=0, go to RESP.
  - Else if counter==TO_CYCLES-1: go to ABORT.
  - If done and timeout occur in the same cycle, done wins.
- ABORT: core_abort_o=1 for one cycle; result=0, err=1; go to RESP.
- RESP:
  - rsp_valid_o=1; id/result/err are registered and held stable until rsp_ready_i=1.
  - On handshake go to IDLE; rsp_valid_o drops in the next cycle.
- req_ready_o is 0 in every state except IDLE. No request is accepted while a job is outstanding.
- core_done_i outside WAIT is ignored, including a late done after an abort.
- Latency (accept cycle T):
  - Bypass: rsp_valid at T+1.
  - Normal: start at T+1, WAIT from T+2; done at cycle D gives rsp_valid at D+1.
  - Timeout: ABORT at T+2+TO_CYCLES, rsp_valid at T+3+TO_CYCLES.
- Fairness: any continuously valid requester is served within N_REQ jobs.
- Reset mid-job:
  - Immediate return to IDLE; outputs cleared; the in-flight job is dropped with no response.
  - The core shares rst and is reset with it.
- Counter width: clog2(TO_CYCLES). Counter saturation is not required because ABORT exits WAIT.

Test Plan:
1. Requester 2 only, a=48 b=18; core model pulses done with result 6 after 7 cycles -> one core_start with a=48 b=18; rsp id=2 result=6 err=0 at done+1.
2. All four requesters held valid with distinct operands, rsp_ready_i=1 -> grant order 0,1,2,3,0; exactly one req_ready_o bit per accept.
3. a=0 b=35 from requester 1 -> rsp result=35 at T+1, core_start_o never asserted. a=0 b=0 -> result 0, err=0.
4. TO_CYCLES=16, core never asserts done -> core_abort_o high exactly one cycle at T+18; rsp err=1 result=0. A late core_done_i afterwards has no effect.
5. rsp_ready_i low for 5 cycles with a pending response -> rsp_valid/id/result stable; no req_ready_o asserted; accepted on the 6th cycle, then the next grant proceeds.
6. rst driven low during WAIT -> all outputs 0 asynchronously, busy_o=0. After release, simultaneous requests 1 and 3 -> requester 1 granted first.
